spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 38 +++
 rtl/spi_slave.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the slave and the master side.
//   SPI_DATA_W      default frame width in bits
//   SPI_SYNC_STAGES default synchronizer depth for the asynchronous SPI pins
//   spi_state_e     protocol FSM states (IDLE, SHIFT)
package spi_pkg;

    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Flop-chain synchronizer with edge detect for one asynchronous input.
//   clk, reset : system clock, async active-high reset
//   d          : asynchronous input
//   q          : synchronized level (last stage of the chain)
//   rise, fall : one-clk pulses on a change of q, found by comparing q with
//                its one-clk-delayed copy
// RESET_VAL is the idle level of the input, so reset produces no false edge.
// STAGES must be at least 2.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            q_d   <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = chain[STAGES-1] & ~q_d;
    assign fall = ~chain[STAGES-1] & q_d;

endmodule

// File: rtl/spi_slave.sv
// SPI mode 0 slave, LSB first, oversampled by clk (clk >= 8x sclk).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | cs_n high; sclk edges ignored, miso not driven
//   SHIFT | frame active; mosi taken on sclk rise, miso moved on sclk fall
//
// Ports:
//   clk, reset             system clock, async active-high reset
//   sclk, cs_n, mosi       SPI pins from the master (asynchronous)
//   miso, miso_oe          serial data to the master and its drive enable
//   tx_data, tx_load       next byte to return, captured while tx_ready
//   tx_ready               transmit holding register empty
//   rx_data, rx_valid      last complete byte and its one-clk update strobe
//   tx_underrun            one-clk pulse: frame began with nothing to send
//   busy                   FSM in SHIFT
//   bit_count              bits received in the current frame
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy,
    output logic [3:0]        bit_count
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_W);

    spi_state_e        state_q, state_nxt;
    logic              sclk_q, sclk_rise, sclk_fall;
    logic              cs_q, cs_rise, cs_fall;
    logic              mosi_q, mosi_rise, mosi_fall;
    logic              frame_start, frame_done, tx_accept;
    logic [DATA_W-1:0] hold_q, tx_sr_q, rx_sr_q, rx_data_q;
    logic              hold_full_q, miso_q, rx_valid_q, tx_underrun_q;
    logic [3:0]        bit_cnt_q;
    logic              unused_sync;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the sclk edges, the cs_n level and the mosi level are needed.
    assign unused_sync = ^{sclk_q, cs_rise, cs_fall, mosi_rise, mosi_fall};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // A byte boundary with cs_n still low starts the next frame in the same
    // clk that reports the completed byte.
    always_comb begin
        state_nxt   = state_q;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_q) begin
                    state_nxt   = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                frame_done = (bit_cnt_q == FULL_CNT);
                if (cs_q) state_nxt = IDLE;
                else      frame_start = frame_done;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The frame-start transfer empties the holding register in the same clk,
    // so a load arriving then is accepted even if tx_ready was low.
    assign tx_accept = tx_load & (~hold_full_q | frame_start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (frame_start) hold_full_q <= 1'b0;
            if (tx_accept) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b0;
            bit_cnt_q     <= '0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            if (frame_done) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
            end
            if (frame_start) begin
                tx_sr_q       <= hold_full_q ? hold_q : '0;
                miso_q        <= hold_full_q & hold_q[0];
                tx_underrun_q <= ~hold_full_q;
                bit_cnt_q     <= '0;
            end else if (state_q == SHIFT) begin
                if (cs_q) begin
                    bit_cnt_q <= '0;
                    miso_q    <= 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_sr_q   <= {mosi_q, rx_sr_q[DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    // The falling edge that trails the last rising edge of a
                    // byte arrives after the count has wrapped to 0; skipping
                    // it keeps bit 0 of the freshly loaded byte on miso.
                    if (sclk_fall && (bit_cnt_q != '0)) begin
                        tx_sr_q <= {1'b0, tx_sr_q[DATA_W-1:1]};
                        miso_q  <= tx_sr_q[1];
                    end
                end
            end
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = ~cs_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = (state_q == SHIFT);
    assign bit_count   = bit_cnt_q;

endmodule
